// File: rtl/dtt_crossbar_switch_pkg.sv
// dtt_crossbar_switch_pkg: shared helpers for the crossbar switch and its arbiter
package dtt_crossbar_switch_pkg;
  // Index width that never collapses to zero bits for single-entry ranges
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dtt_rr_arbiter.sv
// dtt_rr_arbiter: round-robin arbiter with registered priority pointer and one-hot grant
module dtt_rr_arbiter
  import dtt_crossbar_switch_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  localparam int PW = idx_w(N);
  logic [PW-1:0] ptr;
  logic          hit;
  int            gidx;
  // First requester found when scanning from ptr upward, wrapping modulo N
  always_comb begin
    grant = '0;
    hit   = 1'b0;
    gidx  = 0;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++)
        if (!hit && req[i] && ((int'(ptr) + k) % N == i)) begin
          grant[i] = 1'b1;
          hit      = 1'b1;
          gidx     = i;
        end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (hit) ptr <= PW'((gidx + 1) % N);
endmodule

// File: rtl/dtt_crossbar_switch.sv
// dtt_crossbar_switch: N_IN x N_OUT crossbar with one pending slot per input and
// per-output round-robin arbitration, registered outputs with one-edge latency
module dtt_crossbar_switch
  import dtt_crossbar_switch_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int N_OUT      = 4,
  parameter int DATA_WIDTH = 32,
  localparam int DW        = idx_w(N_OUT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data  [N_IN],
  input  logic [DW-1:0]         in_dest  [N_IN],
  input  logic                  in_valid [N_IN],
  output logic [DATA_WIDTH-1:0] out_data [N_OUT],
  output logic                  out_valid[N_OUT]
);
  logic [DATA_WIDTH-1:0] slot_data[N_IN];
  logic [DW-1:0]         slot_dest[N_IN];
  logic [N_IN-1:0]       slot_occ;
  logic [DATA_WIDTH-1:0] src_data [N_IN];
  logic [DW-1:0]         src_dest [N_IN];
  logic [N_IN-1:0]       src_ok;
  logic [N_IN-1:0]       granted;
  logic [N_IN-1:0]       req      [N_OUT];
  logic [N_IN-1:0]       gnt      [N_OUT];
  logic [DATA_WIDTH-1:0] sel_data [N_OUT];
  // An occupied slot masks the live input; out-of-range destinations never request
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      src_data[i] = slot_occ[i] ? slot_data[i] : in_data[i];
      src_dest[i] = slot_occ[i] ? slot_dest[i] : in_dest[i];
      src_ok[i]   = (slot_occ[i] | in_valid[i]) & (int'(src_dest[i]) < N_OUT);
    end
  end
  always_comb begin
    for (int o = 0; o < N_OUT; o++)
      for (int i = 0; i < N_IN; i++)
        req[o][i] = src_ok[i] & (int'(src_dest[i]) == o);
  end
  always_comb begin
    granted = '0;
    for (int o = 0; o < N_OUT; o++) begin
      sel_data[o] = '0;
      for (int i = 0; i < N_IN; i++) begin
        granted[i]  = granted[i] | gnt[o][i];
        sel_data[o] = sel_data[o] | (gnt[o][i] ? src_data[i] : '0);
      end
    end
  end
  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    dtt_rr_arbiter #(.N(N_IN)) u_arb (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req[o]),
      .grant(gnt[o])
    );
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        out_valid[o] <= 1'b0;
        out_data[o]  <= '0;
      end else begin
        out_valid[o] <= |gnt[o];
        if (|gnt[o]) out_data[o] <= sel_data[o];
      end
  end
  // A live request arriving while the slot is full is dropped (no backpressure)
  for (genvar i = 0; i < N_IN; i++) begin : g_in
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        slot_occ[i]  <= 1'b0;
        slot_data[i] <= '0;
        slot_dest[i] <= '0;
      end else if (slot_occ[i]) begin
        if (granted[i]) slot_occ[i] <= 1'b0;
      end else if (src_ok[i] && !granted[i]) begin
        slot_occ[i]  <= 1'b1;
        slot_data[i] <= in_data[i];
        slot_dest[i] <= in_dest[i];
      end
  end
endmodule

// File: tb/tb_dtt_crossbar_switch.sv
// tb_dtt_crossbar_switch: directed and randomized checks of the crossbar against a
// queue-of-one-per-input behavioural model with per-output round-robin scan
module tb_dtt_crossbar_switch;
  localparam int NI = 4;
  localparam int NO = 5;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data  [NI];
  logic [2:0]  in_dest  [NI];
  logic        in_valid [NI];
  logic [31:0] out_data [NO];
  logic        out_valid[NO];
  int checks = 0;
  int errors = 0;
  int          m_ptr [NO];
  bit          m_occ [NI];
  logic [31:0] m_data[NI];
  int          m_dest[NI];
  bit          exp_v [NO];
  logic [31:0] exp_d [NO];

  always #5 clk = ~clk;

  dtt_crossbar_switch #(.N_IN(NI), .N_OUT(NO), .DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each input holds at most one waiting packet; each output scans inputs
  // starting at its pointer and serves the first one aimed at it
  task automatic model_step();
    logic [31:0] d[NI];
    int          dst[NI];
    bit          ok[NI];
    bit          taken[NI];
    if (!rst_n) begin
      for (int o = 0; o < NO; o++) begin
        m_ptr[o] = 0;
        exp_v[o] = 1'b0;
        exp_d[o] = '0;
      end
      for (int i = 0; i < NI; i++) m_occ[i] = 1'b0;
      return;
    end
    for (int i = 0; i < NI; i++) begin
      d[i]     = m_occ[i] ? m_data[i] : in_data[i];
      dst[i]   = m_occ[i] ? m_dest[i] : int'(in_dest[i]);
      ok[i]    = (m_occ[i] || in_valid[i]) && dst[i] < NO;
      taken[i] = 1'b0;
    end
    for (int o = 0; o < NO; o++) begin
      exp_v[o] = 1'b0;
      for (int k = 0; k < NI; k++) begin
        int i;
        i = (m_ptr[o] + k) % NI;
        if (ok[i] && dst[i] == o) begin
          exp_v[o] = 1'b1;
          exp_d[o] = d[i];
          taken[i] = 1'b1;
          m_ptr[o] = (i + 1) % NI;
          break;
        end
      end
    end
    for (int i = 0; i < NI; i++)
      if (m_occ[i]) begin
        if (taken[i]) m_occ[i] = 1'b0;
      end else if (ok[i] && !taken[i]) begin
        m_occ[i]  = 1'b1;
        m_data[i] = in_data[i];
        m_dest[i] = dst[i];
      end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    for (int o = 0; o < NO; o++) begin
      chk($sformatf("out_valid[%0d]", o), 32'(out_valid[o]), 32'(exp_v[o]));
      chk($sformatf("out_data[%0d]", o), out_data[o], exp_d[o]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = '0;
      in_dest[i]  = '0;
    end
  endtask

  task automatic put(input int i, input logic [31:0] d, input int dst);
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    in_dest[i]  = 3'(dst);
  endtask

  initial begin
    logic [31:0] pd[NI];
    idle();
    repeat (3) tick();
    for (int o = 0; o < NO; o++) begin
      chk("rst valid", 32'(out_valid[o]), 0);
      chk("rst data", out_data[o], 0);
    end
    rst_n = 1'b1;
    tick();
    tick();
    chk("post-rst valid2", 32'(out_valid[2]), 0);
    // single-cycle burst
    put(0, 32'hAAAABBBB, 2);
    put(1, 32'hCCCCDDDD, 2);
    put(2, 32'hEEEEFFFF, 1);
    put(3, 32'h11112222, 3);
    tick();
    idle();
    chk("burst e1 v2", 32'(out_valid[2]), 1);
    chk("burst e1 d2", out_data[2], 32'hAAAABBBB);
    chk("burst e1 v1", 32'(out_valid[1]), 1);
    chk("burst e1 d1", out_data[1], 32'hEEEEFFFF);
    chk("burst e1 v3", 32'(out_valid[3]), 1);
    chk("burst e1 d3", out_data[3], 32'h11112222);
    chk("burst e1 v0", 32'(out_valid[0]), 0);
    chk("model e1 d2", exp_d[2], 32'hAAAABBBB);
    tick();
    chk("burst e2 v2", 32'(out_valid[2]), 1);
    chk("burst e2 d2", out_data[2], 32'hCCCCDDDD);
    chk("burst e2 v1", 32'(out_valid[1]), 0);
    chk("burst e2 v3", 32'(out_valid[3]), 0);
    tick();
    chk("burst e3 v2", 32'(out_valid[2]), 0);
    chk("burst e3 hold d2", out_data[2], 32'hCCCCDDDD);
    // fairness on output 0
    for (int c = 0; c < 6; c++) begin
      put(0, 32'(c), 0);
      put(1, 32'h10000000 | 32'(c), 0);
      tick();
      chk($sformatf("fair v0 c%0d", c), 32'(out_valid[0]), 1);
      chk($sformatf("fair src c%0d", c), 32'(out_data[0][31:28]), 32'(c % 2));
    end
    idle();
    chk("fair d0 c5", out_data[0], 32'h10000004);
    tick();
    chk("fair drain d0", out_data[0], 32'h00000005);
    tick();
    chk("fair idle v0", 32'(out_valid[0]), 0);
    // parallel delivery
    for (int i = 0; i < NI; i++) begin
      pd[i] = {4'(i), 28'($urandom)};
      put(i, pd[i], i);
    end
    tick();
    idle();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("par v%0d", i), 32'(out_valid[i]), 1);
      chk($sformatf("par d%0d", i), out_data[i], pd[i]);
    end
    // pending slot blocks a new live packet
    put(0, 32'h0A0A0A0A, 1);
    put(3, 32'h3B3B3B3B, 1);
    tick();
    idle();
    chk("pend e1 d1", out_data[1], 32'h3B3B3B3B);
    put(0, 32'hDEADBEEF, 1);
    tick();
    idle();
    chk("pend e2 v1", 32'(out_valid[1]), 1);
    chk("pend e2 d1", out_data[1], 32'h0A0A0A0A);
    tick();
    chk("pend e3 v1", 32'(out_valid[1]), 0);
    chk("pend e3 d1", out_data[1], 32'h0A0A0A0A);
    // out-of-range destination is discarded
    put(2, 32'h77777777, 6);
    tick();
    idle();
    for (int o = 0; o < NO; o++) chk("bad dest v", 32'(out_valid[o]), 0);
    tick();
    for (int o = 0; o < NO; o++) chk("bad dest late v", 32'(out_valid[o]), 0);
    // mid-operation reset discards the pending packet
    put(0, 32'h55550000, 2);
    put(1, 32'h55551111, 2);
    tick();
    idle();
    chk("mrst v2", 32'(out_valid[2]), 1);
    rst_n = 1'b0;
    #1;
    chk("mrst async v2", 32'(out_valid[2]), 0);
    chk("mrst async d2", out_data[2], 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      for (int o = 0; o < NO; o++) chk("mrst after v", 32'(out_valid[o]), 0);
    end
    // randomized traffic with occasional resets
    repeat (400) begin
      for (int i = 0; i < NI; i++) begin
        in_valid[i] = 1'($urandom_range(0, 1));
        in_data[i]  = $urandom;
        in_dest[i]  = 3'($urandom_range(0, 7));
      end
      rst_n = ($urandom_range(0, 63) != 0);
      tick();
    end
    rst_n = 1'b1;
    idle();
    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
